// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit with HI/LO result registers.
// Sign-magnitude: operands are made unsigned, iterated for ITER cycles, then sign-fixed.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] OP_MULT = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam int         CW      = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               sign_a_q, sign_a_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   abs_a, abs_b, addend;
  logic [WIDTH:0]     msum, rem_sh, diff;
  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // acc holds {partial product, remaining multiplier} for mult and {remainder, quotient} for div
  always_comb begin
    abs_a   = A[WIDTH-1] ? -A : A;
    abs_b   = B[WIDTH-1] ? -B : B;
    addend  = acc_q[0] ? opnd_q : '0;
    msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd_q};
    acc_neg = -acc_q;
    quo_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start && !Flush) begin
          if (ALU_Control == OP_MULT) begin
            state_d  = S_CALC;
            cnt_d    = '0;
            is_div_d = 1'b0;
            neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
            sign_a_d = A[WIDTH-1];
            opnd_d   = abs_a;
            acc_d    = {{WIDTH{1'b0}}, abs_b};
          end else if (ALU_Control == OP_DIV) begin
            if (B == '0) begin
              done_d = 1'b1;
              dbz_d  = 1'b1;
            end else begin
              state_d  = S_CALC;
              cnt_d    = '0;
              is_div_d = 1'b1;
              neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
              sign_a_d = A[WIDTH-1];
              opnd_d   = abs_b;
              acc_d    = {{WIDTH{1'b0}}, abs_a};
            end
          end
        end
      end
      S_CALC: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          if (!is_div_q) begin
            acc_d = {msum, acc_q[WIDTH-1:1]};
          end else if (!diff[WIDTH]) begin
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!Flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = neg_q ? acc_neg : acc_q;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// mult/div traffic checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int         W       = 32;
  localparam logic [3:0] OP_MULT = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Start;
  logic [3:0]   ALU_Control;
  logic [W-1:0] A, B;
  logic         Flush;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  mult_div_unit #(.WIDTH(W), .ITER(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ALU_Control(ALU_Control),
    .A(A), .B(B), .Flush(Flush), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one op, computed with ordinary signed arithmetic.
  task automatic model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit valid, output bit dbz,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo);
    int          sa, sb;
    longint      p;
    logic [63:0] pv;
    sa = a;
    sb = b;
    valid = (code == OP_MULT) || (code == OP_DIV);
    dbz   = (code == OP_DIV) && (b == '0);
    ehi   = hi_m;
    elo   = lo_m;
    if (code == OP_MULT) begin
      p   = longint'(sa) * longint'(sb);
      pv  = p;
      ehi = pv[63:32];
      elo = pv[31:0];
    end else if (code == OP_DIV && !dbz) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        elo = 32'h8000_0000;
        ehi = '0;
      end else begin
        elo = sa / sb;
        ehi = sa % sb;
      end
    end
  endtask

  task automatic run_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int start_at, input int flush_at);
    bit           valid, dbz;
    logic [W-1:0] ehi, elo;
    int           n;
    model(code, a, b, valid, dbz, ehi, elo);
    @(negedge Clk);
    Start = 1'b1; ALU_Control = code; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    if (!valid || dbz) begin
      check("idle_busy", Busy, 0);
      check("imm_done", Done, dbz);
      check("imm_dbz", DivByZero, dbz);
      check("imm_hi", HI, hi_m);
      check("imm_lo", LO, lo_m);
      @(negedge Clk);
      check("imm_done_clr", Done, 0);
      check("imm_dbz_clr", DivByZero, 0);
      return;
    end
    n = 0;
    while (Busy && n < 100) begin
      n++;
      check("early_done", Done, 0);
      Start = 1'b0;
      if (n == start_at) begin
        Start = 1'b1; ALU_Control = OP_DIV; A = $urandom; B = $urandom | 32'h1;
      end
      if (n == flush_at) Flush = 1'b1;
      @(negedge Clk);
      if (Flush) begin
        Flush = 1'b0;
        check("flush_busy", Busy, 0);
        check("flush_done", Done, 0);
        check("flush_hi", HI, hi_m);
        check("flush_lo", LO, lo_m);
        @(negedge Clk);
        check("flush_nodone", Done, 0);
        return;
      end
    end
    Start = 1'b0;
    check("busy_len", n, 33);
    check("done", Done, 1);
    check("done_dbz", DivByZero, 0);
    check("hi", HI, ehi);
    check("lo", LO, elo);
    hi_m = ehi;
    lo_m = elo;
    @(negedge Clk);
    check("done_pulse", Done, 0);
    check("hi_hold", HI, hi_m);
    check("lo_hold", LO, lo_m);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h7FFF_FFFF;
      3: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [3:0]   code;
    logic [W-1:0] ra, rb;
    Reset_n = 1'b0; Start = 1'b0; Flush = 1'b0; ALU_Control = '0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_dbz", DivByZero, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    Reset_n = 1'b1;

    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0, 0);
    check("plan_hi1", HI, 32'hFFFF_FFFF);
    check("plan_lo1", LO, 32'hFFFF_FFEB);
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("plan_lo3", LO, 32'hFFFF_FFFD);
    check("plan_hi3", HI, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(OP_MULT, 32'h0001_2345, 32'h0000_6789, 0, 0);
    run_op(OP_DIV, 32'd5, 32'd0, 0, 0);
    run_op(4'b0010, 32'd1, 32'd2, 0, 0);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'd1, 0, 0);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFD, 0, 0);
    run_op(OP_MULT, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5, 0);
    run_op(OP_DIV, 32'h1234_5678, 32'd99, 0, 10);
    run_op(OP_MULT, 32'hFFFF_FFF0, 32'd3, 0, 20);

    for (int i = 0; i < 30; i++) begin
      code = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? '0 : pick();
      run_op(code, ra, rb, 0, 0);
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge Clk);
    Start = 1'b1; ALU_Control = OP_MULT; A = 32'h0000_1111; B = 32'h0000_2222;
    @(negedge Clk);
    Start = 1'b0;
    repeat (14) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_busy", Busy, 0);
    check("arst_done", Done, 0);
    check("arst_dbz", DivByZero, 0);
    check("arst_hi", HI, 0);
    check("arst_lo", LO, 0);
    hi_m = '0;
    lo_m = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op(OP_DIV, 32'd100, 32'd7, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
